speech_cmd_ctrl: RTL and testbench

Sequencer between the speech-recognition datapath and the LED logic. It repeatedly starts a recognition attempt and waits for the result. A command is accepted only after it is recognised with sufficient score in `CONFIRM_N` consecutive attempts. The block then emits a single-cycle command code on `speech_rec` for the LED logic, and a hold-off window suppresses re-triggering.

---
 rtl/speech_cmd_ctrl_if.sv | 33 +++
 rtl/speech_cmd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_speech_cmd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/speech_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : speech_cmd_ctrl_if
// Description : Handshake bundle between the command sequencer and the
//               speech-recognition datapath.
//               rec_start : one-cycle pulse, sequencer -> recognizer
//               rec_done  : one-cycle pulse, recognizer -> sequencer
//               rec_class : recognised class, valid with rec_done
//               rec_score : confidence score, valid with rec_done
//               master modport = sequencer side, slave = recognizer side.
// Revision    : 1.0  initial release
// ============================================================================
interface speech_cmd_ctrl_if;
    logic       rec_start;
    logic       rec_done;
    logic [1:0] rec_class;
    logic [7:0] rec_score;

    modport master (
        output rec_start,
        input  rec_done,
        input  rec_class,
        input  rec_score
    );

    modport slave (
        input  rec_start,
        output rec_done,
        output rec_class,
        output rec_score
    );
endinterface
`default_nettype wire

// File: rtl/speech_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : speech_cmd_ctrl
// Description : Repeatedly launches recognition attempts and issues a
//               one-cycle command to the LED logic once the same class has
//               been recognised with sufficient score in CONFIRM_N
//               consecutive attempts, followed by a hold-off window.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset
//               enable     - controller enable (user switch)
//               rec        - recognizer handshake (master modport)
//               speech_rec - command code: 00 none, 01 on, 10 off
//               busy       - high whenever the sequencer is not idle
// Revision    : 1.0  initial release
// ============================================================================
module speech_cmd_ctrl #(
    parameter logic [7:0] SCORE_MIN = 8'd128,
    parameter int         CONFIRM_N = 2,
    parameter int         TIMEOUT   = 16_000_000,
    parameter int         HOLDOFF   = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    speech_cmd_ctrl_if.master        rec,
    output logic [1:0]               speech_rec,
    output logic                     busy
);

    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT - 1);
    localparam logic [31:0] c_holdoff_last = 32'(HOLDOFF - 1);
    localparam logic [2:0]  c_confirm      = 3'(CONFIRM_N);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_EVAL    = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_t;

    state_t      state_q,      state_d;
    logic [1:0]  last_class_q, last_class_d;
    logic [2:0]  cnt_q,        cnt_d;
    logic [31:0] timer_q,      timer_d;
    logic [1:0]  cls_q,        cls_d;
    logic [7:0]  score_q,      score_d;

    logic        w_valid;
    logic [2:0]  w_cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_class_q <= 2'b00;
            cnt_q        <= 3'd0;
            timer_q      <= 32'd0;
            cls_q        <= 2'b00;
            score_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_class_q <= last_class_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            cls_q        <= cls_d;
            score_q      <= score_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_class_d = last_class_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        cls_d        = cls_q;
        score_d      = score_q;

        // Only the "on" and "off" classes count, and only with enough score.
        w_valid   = ((cls_q == 2'b01) || (cls_q == 2'b10)) && (score_q >= SCORE_MIN);
        w_cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                timer_d = 32'd0;
                if (!enable) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Disable wins over a result; a result wins over the timeout.
                if (!enable) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else if (rec.rec_done) begin
                    cls_d   = rec.rec_class;
                    score_d = rec.rec_score;
                    state_d = ST_EVAL;
                end else if (timer_q == c_timeout_last) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            ST_EVAL: begin
                if (!enable) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    if (w_valid) begin
                        if (cls_q == last_class_q) begin
                            cnt_d = w_cnt_inc;
                        end else begin
                            cnt_d        = 3'd1;
                            last_class_d = cls_q;
                        end
                    end else begin
                        // Rejected results break the streak but keep the class.
                        cnt_d = 3'd0;
                    end
                    state_d = (cnt_d == c_confirm) ? ST_ISSUE : ST_IDLE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = 3'd0;
                timer_d = 32'd0;
                state_d = ST_HOLDOFF;
            end

            ST_HOLDOFF: begin
                timer_d = timer_q + 32'd1;
                if (timer_q == c_holdoff_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come from registered state only. last_class only ever holds
    // 00, 01 or 10, so speech_rec can never show 11.
    assign speech_rec    = (state_q == ST_ISSUE) ? last_class_q : 2'b00;
    assign rec.rec_start = (state_q == ST_START);
    assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_speech_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_speech_cmd_ctrl
// Description : Self-checking bench for speech_cmd_ctrl. The bench plays the
//               recognizer, drives attempts and compares against an
//               attempt-level reference model of the confirmation rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_speech_cmd_ctrl;

    localparam int TIMEOUT_P = 20;
    localparam int HOLDOFF_P = 10;
    localparam int CONFIRM_P = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] speech_rec;
    logic       busy;

    speech_cmd_ctrl_if rif ();

    speech_cmd_ctrl #(
        .SCORE_MIN (8'd128),
        .CONFIRM_N (CONFIRM_P),
        .TIMEOUT   (TIMEOUT_P),
        .HOLDOFF   (HOLDOFF_P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rec        (rif.master),
        .speech_rec (speech_rec),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: streak length and class of the last valid result.
    int         m_cnt  = 0;
    logic [1:0] m_last = 2'b00;

    function automatic logic [1:0] model_attempt(input logic [1:0] cls, input logic [7:0] score);
        bit valid;
        valid = ((cls == 2'b01) || (cls == 2'b10)) && (score >= 8'd128);
        if (valid) begin
            if (cls == m_last) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            else begin m_cnt = 1; m_last = cls; end
        end else begin
            m_cnt = 0;
        end
        if (m_cnt == CONFIRM_P) begin
            m_cnt = 0;
            return m_last;
        end
        return 2'b00;
    endfunction

    // Entered at the negedge of a START cycle. Presents a result after d WAIT
    // cycles, records speech_rec in the EVAL and following cycle, then counts
    // cycles until the next rec_start while injecting stray rec_done pulses.
    task automatic run_attempt(input logic [1:0] cls, input logic [7:0] score, input int d,
                               output logic [1:0] sr_eval, output logic [1:0] sr_issue,
                               output int gap, output bit stray);
        repeat (d + 1) @(negedge clk);
        rif.rec_done  = 1'b1;
        rif.rec_class = cls;
        rif.rec_score = score;
        @(negedge clk);
        rif.rec_done  = 1'b0;
        rif.rec_class = 2'($urandom);
        rif.rec_score = 8'($urandom);
        sr_eval = speech_rec;
        @(negedge clk);
        sr_issue = speech_rec;
        gap   = 0;
        stray = 1'b0;
        while (gap < 200) begin
            @(negedge clk);
            rif.rec_done = 1'b0;
            gap++;
            if (rif.rec_start === 1'b1) break;
            if (speech_rec !== 2'b00) stray = 1'b1;
            rif.rec_done  = 1'($urandom);
            rif.rec_class = 2'($urandom);
            rif.rec_score = 8'($urandom);
        end
        rif.rec_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0;
        rif.rec_done = 1'b0; rif.rec_class = 2'b00; rif.rec_score = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (rif.rec_start !== 1'b0) $display("FAIL reset_rec_start: got %b expected 0", rif.rec_start); else n_pass++;
        n_checks++; if (speech_rec !== 2'b00) $display("FAIL reset_speech_rec: got %b expected 00", speech_rec); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_when_disabled: busy got %b expected 0", busy); else n_pass++;
        m_cnt = 0; m_last = 2'b00;
    endtask

    // Leaves the bench at the negedge of the first START cycle.
    task automatic test_enable_latency;
        enable = 1'b1;
        @(negedge clk);
        n_checks++; if (rif.rec_start !== 1'b1) $display("FAIL enable_start: rec_start got %b expected 1", rif.rec_start); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL enable_busy: got %b expected 1", busy); else n_pass++;
    endtask

    task automatic test_confirm;
        logic [1:0] clsv [3];
        logic [7:0] scv  [3];
        logic [1:0] exp, sr_e, sr_i;
        int gap;
        bit stray;
        // class 01 twice confirms; the trailing 10 only starts a new streak
        clsv = '{2'b01, 2'b01, 2'b10};
        scv  = '{8'd200, 8'd200, 8'd200};
        for (int i = 0; i < 3; i++) begin
            exp = model_attempt(clsv[i], scv[i]);
            run_attempt(clsv[i], scv[i], $urandom_range(0, 5), sr_e, sr_i, gap, stray);
            n_checks++; if (sr_e !== 2'b00) $display("FAIL confirm_eval_cycle[%0d]: got %b expected 00", i, sr_e); else n_pass++;
            n_checks++; if (sr_i !== exp) $display("FAIL confirm_issue[%0d]: got %b expected %b", i, sr_i, exp); else n_pass++;
            n_checks++; if (gap !== ((exp != 2'b00) ? HOLDOFF_P + 2 : 1)) $display("FAIL confirm_gap[%0d]: got %0d expected %0d", i, gap, (exp != 2'b00) ? HOLDOFF_P + 2 : 1); else n_pass++;
            n_checks++; if (stray !== 1'b0) $display("FAIL confirm_stray[%0d]: got %b expected 0", i, stray); else n_pass++;
        end
    endtask

    task automatic test_class_change_and_reject;
        logic [1:0] clsv [9];
        logic [7:0] scv  [9];
        logic [1:0] exp, sr_e, sr_i;
        int gap;
        bit stray;
        // 01,10,10 issues 10; 01/200,01/127 rejected; 11/255 rejected;
        // 01/128 twice issues 01 (inclusive threshold)
        clsv = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01};
        scv  = '{8'd0, 8'd200, 8'd200, 8'd200, 8'd200, 8'd127, 8'd255, 8'd128, 8'd128};
        for (int i = 0; i < 9; i++) begin
            exp = model_attempt(clsv[i], scv[i]);
            run_attempt(clsv[i], scv[i], $urandom_range(0, TIMEOUT_P - 1), sr_e, sr_i, gap, stray);
            n_checks++; if (sr_i !== exp) $display("FAIL class_issue[%0d]: got %b expected %b", i, sr_i, exp); else n_pass++;
            n_checks++; if (gap !== ((exp != 2'b00) ? HOLDOFF_P + 2 : 1)) $display("FAIL class_gap[%0d]: got %0d expected %0d", i, gap, (exp != 2'b00) ? HOLDOFF_P + 2 : 1); else n_pass++;
            n_checks++; if (stray !== 1'b0) $display("FAIL class_stray[%0d]: got %b expected 0", i, stray); else n_pass++;
        end
    endtask

    task automatic test_timeout;
        logic [1:0] exp, sr_e, sr_i;
        int gap, n;
        bit stray, extra_start;
        exp = model_attempt(2'b01, 8'd200);
        run_attempt(2'b01, 8'd200, 3, sr_e, sr_i, gap, stray);
        // now in START with no result coming
        n = 0; extra_start = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            if (rif.rec_start !== 1'b0) extra_start = 1'b1;
            n++;
        end
        n_checks++; if (n !== TIMEOUT_P) $display("FAIL timeout_wait_cycles: got %0d expected %0d", n, TIMEOUT_P); else n_pass++;
        n_checks++; if (extra_start !== 1'b0) $display("FAIL timeout_rec_start: got %b expected 0", extra_start); else n_pass++;
        @(negedge clk);
        n_checks++; if (rif.rec_start !== 1'b1) $display("FAIL timeout_restart: got %b expected 1", rif.rec_start); else n_pass++;
        m_cnt = 0;
        // results in the final WAIT cycle are still accepted
        for (int i = 0; i < 2; i++) begin
            exp = model_attempt(2'b01, 8'd200);
            run_attempt(2'b01, 8'd200, TIMEOUT_P - 1, sr_e, sr_i, gap, stray);
            n_checks++; if (sr_i !== exp) $display("FAIL timeout_edge_issue[%0d]: got %b expected %b", i, sr_i, exp); else n_pass++;
        end
    endtask

    task automatic test_enable_drop;
        logic [1:0] exp, sr_e, sr_i;
        int gap;
        bit stray, quiet;
        exp = model_attempt(2'b01, 8'd200);
        run_attempt(2'b01, 8'd200, 1, sr_e, sr_i, gap, stray);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy); else n_pass++;
        rif.rec_done = 1'b1; rif.rec_class = 2'b01; rif.rec_score = 8'd200;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rif.rec_done = 1'b0;
            if (busy !== 1'b0 || speech_rec !== 2'b00 || rif.rec_start !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) $display("FAIL drop_quiet: got %b expected 1", quiet); else n_pass++;
        m_cnt = 0;
        enable = 1'b1;
        @(negedge clk);
        n_checks++; if (rif.rec_start !== 1'b1) $display("FAIL drop_reenable: got %b expected 1", rif.rec_start); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            exp = model_attempt(2'b01, 8'd200);
            run_attempt(2'b01, 8'd200, 2, sr_e, sr_i, gap, stray);
            n_checks++; if (sr_i !== exp) $display("FAIL drop_streak[%0d]: got %b expected %b", i, sr_i, exp); else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [1:0] cls, exp, sr_e, sr_i;
        logic [7:0] score;
        int r, gap;
        bit stray;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            cls = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
            r = $urandom_range(0, 3);
            score = (r == 0) ? 8'd127 : (r == 1) ? 8'd128 : 8'($urandom_range(0, 255));
            exp = model_attempt(cls, score);
            run_attempt(cls, score, $urandom_range(0, TIMEOUT_P - 1), sr_e, sr_i, gap, stray);
            n_checks++; if (sr_e !== 2'b00) $display("FAIL rand_eval[%0d]: got %b expected 00", i, sr_e); else n_pass++;
            n_checks++; if (sr_i !== exp) $display("FAIL rand_issue[%0d]: got %b expected %b (cls %b score %0d)", i, sr_i, exp, cls, score); else n_pass++;
            n_checks++; if (gap !== ((exp != 2'b00) ? HOLDOFF_P + 2 : 1)) $display("FAIL rand_gap[%0d]: got %0d expected %0d", i, gap, (exp != 2'b00) ? HOLDOFF_P + 2 : 1); else n_pass++;
            n_checks++; if (stray !== 1'b0) $display("FAIL rand_stray[%0d]: got %b expected 0", i, stray); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0] exp, sr_e, sr_i;
        int gap;
        bit stray;
        exp = model_attempt(2'b00, 8'd200);
        run_attempt(2'b00, 8'd200, 0, sr_e, sr_i, gap, stray);
        exp = model_attempt(2'b01, 8'd200);
        run_attempt(2'b01, 8'd200, 0, sr_e, sr_i, gap, stray);
        // v = 0: reset during ISSUE; v = 1: reset four cycles into HOLDOFF
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            rif.rec_done = 1'b1; rif.rec_class = 2'b01; rif.rec_score = 8'd200;
            @(negedge clk);
            rif.rec_done = 1'b0;
            @(negedge clk);
            n_checks++; if (speech_rec !== 2'b01) $display("FAIL rstmid_issue[%0d]: got %b expected 01", v, speech_rec); else n_pass++;
            repeat (v * 4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            n_checks++; if (speech_rec !== 2'b00) $display("FAIL rstmid_speech_rec[%0d]: got %b expected 00", v, speech_rec); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy[%0d]: got %b expected 0", v, busy); else n_pass++;
            n_checks++; if (rif.rec_start !== 1'b0) $display("FAIL rstmid_rec_start[%0d]: got %b expected 0", v, rif.rec_start); else n_pass++;
            m_cnt = 0; m_last = 2'b00;
            @(negedge clk);
            n_checks++; if (rif.rec_start !== 1'b1) $display("FAIL rstmid_restart[%0d]: got %b expected 1", v, rif.rec_start); else n_pass++;
            exp = model_attempt(2'b01, 8'd200);
            run_attempt(2'b01, 8'd200, 1, sr_e, sr_i, gap, stray);
            n_checks++; if (sr_i !== exp) $display("FAIL rstmid_after[%0d]: got %b expected %b", v, sr_i, exp); else n_pass++;
            n_checks++; if (stray !== 1'b0) $display("FAIL rstmid_stray[%0d]: got %b expected 0", v, stray); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_enable_latency();
        test_confirm();
        test_class_change_and_reject();
        test_timeout();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks done", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
